trap_arbiter: RTL and testbench
===============================

TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of each IRQ synchronizer (legal values 2..4).
REQ-002 SHALL have parameter IRQ_BADADDR, default 32'hFFFF_FFFF, meaning the badaddr reported for interrupts.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 irq_msi, irq_mti, irq_mei  input  1 each  asynchronous software, timer and external interrupt lines.
REQ-006 mie  input  32  interrupt-enable CSR value.
REQ-007 mstatus_mie  input  1  global machine interrupt enable.
REQ-008 privilege_mode  input  2  current privilege (3 = machine, 0 = user).
REQ-009 insn_boundary  input  1  main FSM is at an instruction fetch boundary; interrupts may be taken only here.
REQ-010 exc_req  input  1  synchronous exception request from the datapath.
REQ-011 exc_cause  input  32  cause code for exc_req.
REQ-012 exc_badaddr  input  32  badaddr for exc_req.
REQ-013 wfi  input  1  WFI instruction is executing.
REQ-014 trap_ack  input  1  CSR unit has accepted the trap (mepc, mcause and mtval written).
REQ-015 trap_valid  output  1  trap request to the CSR unit (drives exception_event).
REQ-016 trap_cause  output  32  mcause value.
REQ-017 trap_badaddr  output  32  mtval source.
REQ-018 mip_pending  output  32  synchronized pending bits: bit 3 MSIP, bit 7 MTIP, bit 11 MEIP, all other bits 0.
REQ-019 wfi_stall  output  1  hold the core while sleeping.
REQ-020 busy  output  1  FSM is not in IDLE.

Function
REQ-021 Each irq_* SHALL pass through SYNC_STAGES flops, so a pin edge reaches mip_pending after exactly SYNC_STAGES cycles.
REQ-022 enabled = mip_pending & mie; global_en = mstatus_mie OR (privilege_mode != 3).
REQ-023 Interrupt priority SHALL be MEI(11) > MSI(3) > MTI(7); interrupt cause = {1'b1, 27'b0, code}.
REQ-024 FSM states SHALL be IDLE, TRAP and SLEEP, encoded in the package.
REQ-025 IDLE transitions, in priority order:
- exc_req -> TRAP, latching exc_cause and exc_badaddr.
- insn_boundary & global_en & |enabled -> TRAP, latching the highest-priority cause and IRQ_BADADDR.
- wfi -> SLEEP.
REQ-026 Causes SHALL be latched on entry to TRAP; trap_valid = 1 starting the cycle after the IDLE decision (1-cycle latency).
REQ-027 In TRAP: trap_valid stays high, and trap_cause/trap_badaddr stay stable, until trap_ack is sampled high; the FSM then goes to IDLE and trap_valid is 0 the next cycle.
REQ-028 trap_ack sampled outside TRAP SHALL be ignored.
REQ-029 exc_req and an eligible interrupt in the same cycle: the exception SHALL win; the interrupt stays pending and is re-evaluated at the next boundary in IDLE.
REQ-030 exc_req, wfi or a new interrupt arriving while in TRAP SHALL be ignored (no queueing).
REQ-031 SLEEP: wfi_stall = 1 (combinational from state).
- Exit to IDLE when |enabled, regardless of global_en.
- exc_req in SLEEP -> TRAP.
REQ-032 Interrupt deassertion before trap entry SHALL cancel the take; no trap is issued for a deasserted interrupt.
REQ-033 busy = (state != IDLE).

Reset
REQ-034 On resetn low, asynchronously: state = IDLE, all synchronizer flops = 0, trap_valid = 0, trap_cause = 0, trap_badaddr = 0, mip_pending = 0, wfi_stall = 0, busy = 0.
REQ-035 Reset during TRAP or SLEEP SHALL abandon the trap without any ack.

Structure
REQ-036 A shared package SHALL hold the FSM state typedef, the interrupt cause codes (3, 7, 11), the MIP bit indices and the interrupt-flag bit position (31).
REQ-037 One sub-module, irq_synchronizer (parameterized depth, async reset to 0), SHALL be instantiated once per IRQ line.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- irq_mti rises, mie[7] = 1, mstatus_mie = 1, insn_boundary = 1 -> mip_pending[7] after 2 cycles; trap_valid with trap_cause = 32'h8000_0007, trap_badaddr = 32'hFFFF_FFFF.
- irq_mei and irq_msi rise together, both enabled -> trap_cause = 32'h8000_000B; after ack and return to IDLE, the next boundary traps with 32'h8000_0003.
- exc_req with exc_cause = 2 and exc_badaddr = 32'h1234 in the same cycle as an enabled MTI -> trap_cause = 2, trap_badaddr = 32'h1234; MTI trap follows after ack.
- wfi with mstatus_mie = 0 and mie[7] = 1, then irq_mti -> wfi_stall = 1 until mip_pending[7], then IDLE; no trap issued (global_en = 0, privilege_mode = 3).
- trap_ack withheld for 10 cycles -> trap_valid and trap_cause are stable throughout; resetn pulsed mid-TRAP -> trap_valid = 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/trap_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// trap_arbiter_pkg
// Shared definitions for the trap arbiter: FSM state encoding, machine
// interrupt cause codes, MIP bit positions, the interrupt flag bit of mcause
// and a helper that builds an interrupt mcause value from a cause code.
// -----------------------------------------------------------------------------
package trap_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_SLEEP = 2'd2
  } state_e;

  // Machine interrupt cause codes (mcause[3:0] for interrupts)
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  // Bit positions inside mip / mie
  localparam int unsigned MIP_MSI_BIT = 3;
  localparam int unsigned MIP_MTI_BIT = 7;
  localparam int unsigned MIP_MEI_BIT = 11;

  // mcause bit that flags an interrupt (as opposed to an exception)
  localparam int unsigned IRQ_FLAG_BIT = 31;

  // Build {1'b1, 27'b0, code}
  function automatic logic [31:0] irq_cause(input logic [3:0] code);
    logic [31:0] cause;
    cause               = 32'h0000_0000;
    cause[IRQ_FLAG_BIT] = 1'b1;
    cause[3:0]          = code;
    return cause;
  endfunction

endpackage

// File: rtl/trap_arbiter_if.sv
// -----------------------------------------------------------------------------
// trap_arbiter_if
// Trap handshake between the trap arbiter (master) and the CSR unit (slave).
//   trap_valid   : trap request, held until acknowledged
//   trap_cause   : mcause value, stable while trap_valid is high
//   trap_badaddr : mtval source, stable while trap_valid is high
//   trap_ack     : CSR unit has written mepc/mcause/mtval
// -----------------------------------------------------------------------------
interface trap_arbiter_if;
  import trap_arbiter_pkg::*;

  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_badaddr;
  logic        trap_ack;

  modport master (
    output trap_valid,
    output trap_cause,
    output trap_badaddr,
    input  trap_ack
  );

  modport slave (
    input  trap_valid,
    input  trap_cause,
    input  trap_badaddr,
    output trap_ack
  );

endinterface

// File: rtl/trap_arbiter_irq_synchronizer.sv
// -----------------------------------------------------------------------------
// irq_synchronizer
// Multi-flop synchronizer for one asynchronous interrupt line. A level change
// on irq_i appears on irq_o exactly STAGES rising edges later.
//   clk    : sampling clock
//   resetn : asynchronous active-low reset, clears every stage to 0
//   irq_i  : asynchronous interrupt pin
//   irq_o  : synchronized level (last flop of the chain)
// -----------------------------------------------------------------------------
module irq_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic irq_i,
  output logic irq_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the pin level one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], irq_i};
  end

  // Synchronizer chain register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign irq_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_arbiter.sv
// -----------------------------------------------------------------------------
// trap_arbiter
// Decides when the core takes a trap. Synchronous exceptions and the three
// machine interrupts (MEI > MSI > MTI) are arbitrated in IDLE; the winning
// cause is latched and presented on the trap handshake until the CSR unit
// acknowledges it. WFI parks the FSM in SLEEP until any enabled interrupt
// is pending, independent of the global interrupt enable.
//   clk, resetn       : clock, asynchronous active-low reset
//   irq_msi/mti/mei   : asynchronous interrupt pins
//   mie, mstatus_mie  : per-source and global interrupt enables
//   privilege_mode    : current privilege (3 = machine)
//   insn_boundary     : interrupts may only be taken when high
//   exc_req/cause/... : synchronous exception request from the datapath
//   wfi               : WFI instruction executing
//   trap_bus          : trap request/ack handshake to the CSR unit
//   mip_pending       : synchronized pending bits 3/7/11
//   wfi_stall         : hold the core while sleeping
//   busy              : FSM not in IDLE
// -----------------------------------------------------------------------------
module trap_arbiter
  import trap_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] IRQ_BADADDR = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  irq_msi,
  input  logic                  irq_mti,
  input  logic                  irq_mei,
  input  logic [31:0]           mie,
  input  logic                  mstatus_mie,
  input  logic [1:0]            privilege_mode,
  input  logic                  insn_boundary,
  input  logic                  exc_req,
  input  logic [31:0]           exc_cause,
  input  logic [31:0]           exc_badaddr,
  input  logic                  wfi,
  trap_arbiter_if.master        trap_bus,
  output logic [31:0]           mip_pending,
  output logic                  wfi_stall,
  output logic                  busy
);

  state_e      state_q, state_d;
  logic [31:0] trap_cause_q, trap_cause_d;
  logic [31:0] trap_badaddr_q, trap_badaddr_d;

  logic        msi_sync_s;
  logic        mti_sync_s;
  logic        mei_sync_s;
  logic [31:0] enabled_s;
  logic        global_en_s;
  logic        irq_any_s;
  logic [3:0]  irq_code_s;

  irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_msi (
    .clk    (clk),
    .resetn (resetn),
    .irq_i  (irq_msi),
    .irq_o  (msi_sync_s)
  );

  irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_mti (
    .clk    (clk),
    .resetn (resetn),
    .irq_i  (irq_mti),
    .irq_o  (mti_sync_s)
  );

  irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_mei (
    .clk    (clk),
    .resetn (resetn),
    .irq_i  (irq_mei),
    .irq_o  (mei_sync_s)
  );

  // Place synchronized levels at their mip bit positions
  always_comb begin
    mip_pending              = 32'h0000_0000;
    mip_pending[MIP_MSI_BIT] = msi_sync_s;
    mip_pending[MIP_MTI_BIT] = mti_sync_s;
    mip_pending[MIP_MEI_BIT] = mei_sync_s;
  end

  // Interrupt eligibility; lower privilege modes always see M-mode interrupts
  always_comb begin
    enabled_s   = mip_pending & mie;
    global_en_s = mstatus_mie | (privilege_mode != 2'd3);
    irq_any_s   = |enabled_s;
  end

  // Fixed priority MEI > MSI > MTI; MTI is the fall-through because only
  // bits 3/7/11 can ever be set in enabled_s
  always_comb begin
    if (enabled_s[MIP_MEI_BIT]) begin
      irq_code_s = CODE_MEI;
    end else if (enabled_s[MIP_MSI_BIT]) begin
      irq_code_s = CODE_MSI;
    end else begin
      irq_code_s = CODE_MTI;
    end
  end

  // Next-state and cause latching; cause/badaddr only change on TRAP entry
  always_comb begin
    state_d        = state_q;
    trap_cause_d   = trap_cause_q;
    trap_badaddr_d = trap_badaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          state_d        = ST_TRAP;
          trap_cause_d   = exc_cause;
          trap_badaddr_d = exc_badaddr;
        end else if (insn_boundary && global_en_s && irq_any_s) begin
          state_d        = ST_TRAP;
          trap_cause_d   = irq_cause(irq_code_s);
          trap_badaddr_d = IRQ_BADADDR;
        end else if (wfi) begin
          state_d = ST_SLEEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: begin
        // New requests are dropped here, not queued
        if (trap_bus.trap_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_SLEEP: begin
        if (exc_req) begin
          state_d        = ST_TRAP;
          trap_cause_d   = exc_cause;
          trap_badaddr_d = exc_badaddr;
        end else if (irq_any_s) begin
          // Wake-up ignores global_en; the trap decision happens in IDLE
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SLEEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and latched trap information
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      trap_cause_q   <= 32'h0000_0000;
      trap_badaddr_q <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      trap_cause_q   <= trap_cause_d;
      trap_badaddr_q <= trap_badaddr_d;
    end
  end

  assign trap_bus.trap_valid   = (state_q == ST_TRAP);
  assign trap_bus.trap_cause   = trap_cause_q;
  assign trap_bus.trap_badaddr = trap_badaddr_q;
  assign wfi_stall             = (state_q == ST_SLEEP);
  assign busy                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trap_arbiter
// Directed scenarios followed by random traffic, all checked each cycle
// against a behavioural model of the trap rules kept in this bench.
// -----------------------------------------------------------------------------
module tb_trap_arbiter;

  localparam int S = 2;

  logic        clk;
  logic        resetn;
  logic        irq_msi, irq_mti, irq_mei;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic [1:0]  privilege_mode;
  logic        insn_boundary;
  logic        exc_req;
  logic [31:0] exc_cause;
  logic [31:0] exc_badaddr;
  logic        wfi;
  logic [31:0] mip_pending;
  logic        wfi_stall;
  logic        busy;

  trap_arbiter_if tbus ();

  trap_arbiter #(.SYNC_STAGES(S), .IRQ_BADADDR(32'hFFFF_FFFF)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .irq_msi        (irq_msi),
    .irq_mti        (irq_mti),
    .irq_mei        (irq_mei),
    .mie            (mie),
    .mstatus_mie    (mstatus_mie),
    .privilege_mode (privilege_mode),
    .insn_boundary  (insn_boundary),
    .exc_req        (exc_req),
    .exc_cause      (exc_cause),
    .exc_badaddr    (exc_badaddr),
    .wfi            (wfi),
    .trap_bus       (tbus),
    .mip_pending    (mip_pending),
    .wfi_stall      (wfi_stall),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  logic [2:0]  hist[$];      // sampled pins {mei, mti, msi}, one entry per edge
  logic [31:0] m_mip;
  bit          m_trap;
  bit          m_sleep;
  logic [31:0] m_cause;
  logic [31:0] m_badaddr;

  function automatic logic [31:0] mip_from_hist();
    logic [31:0] m;
    logic [2:0]  v;
    m = 32'h0;
    if (hist.size() >= S) begin
      v     = hist[hist.size() - S];
      m[3]  = v[0];
      m[7]  = v[1];
      m[11] = v[2];
    end
    return m;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S - 1; i++) hist.push_back(3'b000);
    m_mip     = 32'h0;
    m_trap    = 1'b0;
    m_sleep   = 1'b0;
    m_cause   = 32'h0;
    m_badaddr = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] en;
    bit          gen;
    int          code;
    en  = m_mip & mie;
    gen = mstatus_mie || (privilege_mode != 2'd3);
    if (en[11])     code = 11;
    else if (en[3]) code = 3;
    else            code = 7;
    if (m_trap) begin
      if (tbus.trap_ack) m_trap = 1'b0;
    end else if (m_sleep) begin
      if (exc_req) begin
        m_sleep = 1'b0; m_trap = 1'b1;
        m_cause = exc_cause; m_badaddr = exc_badaddr;
      end else if (en != 32'h0) begin
        m_sleep = 1'b0;
      end
    end else begin
      if (exc_req) begin
        m_trap = 1'b1; m_cause = exc_cause; m_badaddr = exc_badaddr;
      end else if (insn_boundary && gen && (en != 32'h0)) begin
        m_trap = 1'b1; m_cause = 32'h8000_0000 + code; m_badaddr = 32'hFFFF_FFFF;
      end else if (wfi) begin
        m_sleep = 1'b1;
      end
    end
    hist.push_back({irq_mei, irq_mti, irq_msi});
    if (hist.size() > 8) void'(hist.pop_front());
    m_mip = mip_from_hist();
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("trap_valid",   {31'b0, tbus.trap_valid}, {31'b0, m_trap});
    chk("busy",         {31'b0, busy},            {31'b0, (m_trap || m_sleep)});
    chk("wfi_stall",    {31'b0, wfi_stall},       {31'b0, m_sleep});
    chk("mip_pending",  mip_pending,              m_mip);
    chk("trap_cause",   tbus.trap_cause,          m_cause);
    chk("trap_badaddr", tbus.trap_badaddr,        m_badaddr);
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  // Reset asserted between edges; checked while held, released before next edge
  task automatic reset_pulse();
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_valid", {31'b0, tbus.trap_valid}, 32'h0);
    chk("rst_busy",  {31'b0, busy},            32'h0);
    chk("rst_cause", tbus.trap_cause,          32'h0);
    #1;
    resetn = 1'b1;
  endtask

  task automatic release_trap();
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    insn_boundary = 1'b0; exc_req = 1'b0; wfi = 1'b0;
    cycle(3);
    tbus.trap_ack = 1'b1;
    cycle(1);
    tbus.trap_ack = 1'b0;
    cycle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    mie = 32'h0; mstatus_mie = 1'b0; privilege_mode = 2'd3;
    insn_boundary = 1'b0; exc_req = 1'b0; exc_cause = 32'h0;
    exc_badaddr = 32'h0; wfi = 1'b0; tbus.trap_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_mip",   mip_pending,     32'h0);
    chk("reset_cause", tbus.trap_cause, 32'h0);
    #1;
    resetn = 1'b1;

    // MTI: 2-cycle synchronizer latency, then trap
    mie = 32'h0000_0080; mstatus_mie = 1'b1; insn_boundary = 1'b1; irq_mti = 1'b1;
    cycle(1);
    chk("mti_mip_1cyc", mip_pending, 32'h0);
    cycle(1);
    chk("mti_mip_2cyc", mip_pending, 32'h0000_0080);
    cycle(1);
    chk("mti_valid",   {31'b0, tbus.trap_valid}, 32'h1);
    chk("mti_cause",   tbus.trap_cause,   32'h8000_0007);
    chk("mti_badaddr", tbus.trap_badaddr, 32'hFFFF_FFFF);
    release_trap();
    chk("mti_released", {31'b0, tbus.trap_valid}, 32'h0);

    // MEI and MSI together: MEI first, MSI after ack
    mie = 32'h0000_0808; irq_mei = 1'b1; irq_msi = 1'b1; insn_boundary = 1'b1;
    cycle(3);
    chk("mei_cause", tbus.trap_cause, 32'h8000_000B);
    irq_mei = 1'b0;
    cycle(3);
    tbus.trap_ack = 1'b1;
    cycle(1);
    chk("mei_acked", {31'b0, tbus.trap_valid}, 32'h0);
    tbus.trap_ack = 1'b0;
    cycle(1);
    chk("msi_cause", tbus.trap_cause, 32'h8000_0003);
    release_trap();

    // Exception beats a simultaneous MTI; MTI follows after ack
    mie = 32'h0000_0080; irq_mti = 1'b1; insn_boundary = 1'b0;
    cycle(3);
    chk("exc_pre_idle", {31'b0, tbus.trap_valid}, 32'h0);
    exc_req = 1'b1; exc_cause = 32'h2; exc_badaddr = 32'h1234; insn_boundary = 1'b1;
    cycle(1);
    chk("exc_cause",   tbus.trap_cause,   32'h0000_0002);
    chk("exc_badaddr", tbus.trap_badaddr, 32'h0000_1234);
    exc_req = 1'b0; tbus.trap_ack = 1'b1;
    cycle(1);
    tbus.trap_ack = 1'b0;
    cycle(1);
    chk("exc_then_mti", tbus.trap_cause,   32'h8000_0007);
    chk("exc_then_bad", tbus.trap_badaddr, 32'hFFFF_FFFF);
    release_trap();

    // WFI wakes on enabled MTI even with global interrupts off; no trap
    mstatus_mie = 1'b0; privilege_mode = 2'd3; mie = 32'h0000_0080; wfi = 1'b1;
    cycle(1);
    wfi = 1'b0;
    chk("wfi_stall_on", {31'b0, wfi_stall}, 32'h1);
    irq_mti = 1'b1;
    cycle(2);
    chk("wfi_still_stall", {31'b0, wfi_stall}, 32'h1);
    chk("wfi_mip",         mip_pending,        32'h0000_0080);
    cycle(1);
    chk("wfi_woken", {31'b0, wfi_stall}, 32'h0);
    insn_boundary = 1'b1;
    cycle(3);
    chk("wfi_no_trap", {31'b0, tbus.trap_valid}, 32'h0);
    irq_mti = 1'b0; insn_boundary = 1'b0;
    cycle(3);

    // Ack withheld: outputs stable, extra requests ignored; then reset mid-TRAP
    mstatus_mie = 1'b1; irq_mti = 1'b1; insn_boundary = 1'b1;
    cycle(3);
    irq_mti = 1'b0; insn_boundary = 1'b0; exc_req = 1'b1; exc_cause = 32'h5; wfi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      chk("hold_valid", {31'b0, tbus.trap_valid}, 32'h1);
      chk("hold_cause", tbus.trap_cause,          32'h8000_0007);
    end
    exc_req = 1'b0; wfi = 1'b0;
    reset_pulse();
    cycle(2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) irq_msi = ~irq_msi;
      if ($urandom_range(0, 7) == 0) irq_mti = ~irq_mti;
      if ($urandom_range(0, 7) == 0) irq_mei = ~irq_mei;
      if ($urandom_range(0, 15) == 0) mie = $urandom();
      mstatus_mie    = ($urandom_range(0, 3) != 0);
      privilege_mode = ($urandom_range(0, 3) != 0) ? 2'd3 : 2'd0;
      insn_boundary  = ($urandom_range(0, 1) == 1);
      exc_req        = ($urandom_range(0, 7) == 0);
      exc_cause      = $urandom_range(0, 15);
      exc_badaddr    = $urandom();
      wfi            = ($urandom_range(0, 5) == 0);
      tbus.trap_ack  = ($urandom_range(0, 2) == 0);
      cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
